// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/IDIV (32/16 word, 16/8 byte), STEPS quotient bits per cycle.
// Optional macro DIV_ABORT_EN adds an abort input that cancels an operation in flight.
module div_seq #(
  parameter int STEPS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        word_op,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
`ifdef DIV_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        done,
  output logic        exc,
  output logic [31:0] result
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  localparam logic [3:0] CNT_WORD = 4'(16 / STEPS - 1);
  localparam logic [3:0] CNT_BYTE = 4'(8 / STEPS - 1);

  state_t      state_reg, state_next;
  logic        word_reg, signed_reg;
  logic [31:0] dvd_reg;
  logic [15:0] dvs_reg;
  logic [15:0] rem_reg, quo_reg, mag_reg;
  logic [3:0]  cnt_reg;
  logic        neg_q_reg, neg_r_reg, big_reg;
  logic        exc_reg;
  logic [31:0] result_reg;
  logic        abort_hit;

`ifdef DIV_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Operand magnitudes; byte ops are aligned into the top of the 16-bit datapath
  // so the same shift loop leaves the 8-bit quotient in quo_reg[7:0].
  logic        sd, sv, div_zero, big;
  logic [31:0] dvd_abs;
  logic [15:0] dvd_abs_b, hi_mag, lo_mag, dvs_mag;
  logic [7:0]  dvs_abs_b;

  always_comb begin
    dvd_abs   = dvd_reg;
    dvd_abs_b = dvd_reg[15:0];
    dvs_abs_b = dvs_reg[7:0];
    if (word_reg) begin
      sd = signed_reg & dvd_reg[31];
      sv = signed_reg & dvs_reg[15];
      if (sd) dvd_abs = -dvd_reg;
      hi_mag  = dvd_abs[31:16];
      lo_mag  = dvd_abs[15:0];
      dvs_mag = sv ? -dvs_reg : dvs_reg;
    end else begin
      sd = signed_reg & dvd_reg[15];
      sv = signed_reg & dvs_reg[7];
      if (sd) dvd_abs_b = -dvd_reg[15:0];
      if (sv) dvs_abs_b = -dvs_reg[7:0];
      hi_mag  = {8'h00, dvd_abs_b[15:8]};
      lo_mag  = {dvd_abs_b[7:0], 8'h00};
      dvs_mag = {8'h00, dvs_abs_b};
    end
    div_zero = (dvs_mag == 16'h0000);
    big      = (hi_mag >= dvs_mag);
  end

  logic [15:0] it_rem, it_quo;
  logic [16:0] sh;

  always_comb begin
    it_rem = rem_reg;
    it_quo = quo_reg;
    sh     = '0;
    for (int i = 0; i < STEPS; i++) begin
      sh     = {it_rem, it_quo[15]};
      it_quo = {it_quo[14:0], 1'b0};
      if (sh >= {1'b0, mag_reg}) begin
        sh        = sh - {1'b0, mag_reg};
        it_quo[0] = 1'b1;
      end
      it_rem = sh[15:0];
    end
  end

  // A signed quotient may reach -2^(n-1) but only 2^(n-1)-1 when positive.
  logic [15:0] q_val, r_val;
  logic        ovf, fix_exc;
  logic [31:0] fix_result;

  always_comb begin
    q_val = neg_q_reg ? -quo_reg : quo_reg;
    r_val = neg_r_reg ? -rem_reg : rem_reg;
    if (word_reg) ovf = neg_q_reg ? (quo_reg > 16'h8000) : (quo_reg > 16'h7FFF);
    else          ovf = neg_q_reg ? (quo_reg > 16'h0080) : (quo_reg > 16'h007F);
    fix_exc    = signed_reg & (big_reg | ovf);
    fix_result = 32'h0000_0000;
    if (!fix_exc)
      fix_result = word_reg ? {r_val, q_val} : {16'h0000, r_val[7:0], q_val[7:0]};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = PREP;
      PREP: begin
        if (abort_hit)                           state_next = IDLE;
        else if (div_zero || (!signed_reg && big)) state_next = DONE;
        else                                     state_next = ITER;
      end
      ITER: begin
        if (abort_hit)             state_next = IDLE;
        else if (cnt_reg == 4'd0)  state_next = FIX;
      end
      FIX:     state_next = abort_hit ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg   <= 1'b0;
      signed_reg <= 1'b0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      mag_reg    <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      big_reg    <= 1'b0;
      exc_reg    <= 1'b0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          word_reg   <= word_op;
          signed_reg <= signed_op;
          dvd_reg    <= dividend;
          dvs_reg    <= divisor;
        end
        PREP: begin
          rem_reg   <= hi_mag;
          quo_reg   <= lo_mag;
          mag_reg   <= dvs_mag;
          cnt_reg   <= word_reg ? CNT_WORD : CNT_BYTE;
          neg_q_reg <= sd ^ sv;
          neg_r_reg <= sd;
          big_reg   <= big;
          if (state_next == DONE) begin
            exc_reg    <= 1'b1;
            result_reg <= '0;
          end
        end
        ITER: begin
          rem_reg <= it_rem;
          quo_reg <= it_quo;
          cnt_reg <= cnt_reg - 4'd1;
        end
        FIX: if (state_next == DONE) begin
          exc_reg    <= fix_exc;
          result_reg <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
  assign done   = (state_reg == DONE);
  assign exc    = exc_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: arithmetic reference model with per-cycle compare,
// plus directed operations with hand-computed results and done cycles.
`timescale 1ns/1ps
module tb_div_seq;
  localparam int STEPS = 1;

  logic        clk, rst, start, word_op, signed_op;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, exc;
  logic [31:0] result;
`ifdef DIV_ABORT_EN
  logic        abort;
`endif

  int tests = 0;
  int fails = 0;

  div_seq #(.STEPS(STEPS)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .word_op(word_op),
    .signed_op(signed_op),
    .dividend(dividend),
    .divisor(divisor),
`ifdef DIV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .exc(exc),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  // Reference: plain integer division with x86 DIV/IDIV error rules.
  function automatic void ref_div(input logic w, input logic s, input logic [31:0] a,
                                  input logic [15:0] b, output logic [31:0] res,
                                  output logic ex, output int lat);
    longint na, nb, q, r;
    int n;
    n = w ? 16 : 8;
    if (w) begin
      na = s ? longint'($signed(a)) : longint'(a);
      nb = s ? longint'($signed(b)) : longint'(b);
    end else begin
      na = s ? longint'($signed(a[15:0])) : longint'(a[15:0]);
      nb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
    end
    res = '0;
    ex  = 1'b0;
    lat = n / STEPS + 3;
    if (nb == 0) begin ex = 1'b1; lat = 2; return; end
    q = na / nb;
    r = na % nb;
    if (!s && q >= (longint'(1) << n)) begin ex = 1'b1; lat = 2; return; end
    if (s && (q < -(longint'(1) << (n - 1)) || q > (longint'(1) << (n - 1)) - 1)) begin
      ex = 1'b1;
      return;
    end
    res = w ? {r[15:0], q[15:0]} : {16'h0000, r[7:0], q[7:0]};
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_exc  = 1'b0, p_exc = 1'b0;
  logic [31:0] m_res  = '0, p_res = '0;

  always @(posedge clk) begin
    logic prev_done;
    int   lat;
    prev_done = m_done;
    m_done    = 1'b0;
    if (rst) begin
      m_left = 0;
      m_res  = '0;
      m_exc  = 1'b0;
    end
`ifdef DIV_ABORT_EN
    else if (abort && m_left > 0) m_left = 0;
`endif
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_res  = p_res;
        m_exc  = p_exc;
      end
    end else if (start && !prev_done) begin
      ref_div(word_op, signed_op, dividend, divisor, p_res, p_exc, lat);
      m_left = lat - 1;
    end
  end

  always @(negedge clk) begin
    check("cyc busy", 32'(busy), 32'(m_left > 0));
    check("cyc done", 32'(done), 32'(m_done));
    if (m_left == 0) begin
      check("cyc result", result, m_res);
      check("cyc exc", 32'(exc), 32'(m_exc));
    end
  end

  task automatic run_op(input string nm, input logic w, input logic s, input logic [31:0] a,
                        input logic [15:0] b, input logic [31:0] er, input logic ee,
                        input int ecyc, input int restart_at);
    int cyc;
    bit seen;
    @(negedge clk);
    word_op = w; signed_op = s; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    cyc = 1;
    start = 1'b0; word_op = ~w; signed_op = ~s; dividend = ~a; divisor = ~b;
    seen = 1'b0;
    while (cyc < 60) begin
      if (done) begin seen = 1'b1; break; end
      if (cyc == restart_at) begin
        start = 1'b1; word_op = 1'b1; signed_op = 1'b0;
        dividend = 32'h0000_0001; divisor = 16'h0001;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({nm, " done seen"}, 32'(seen), 32'd1);
    check({nm, " cycle"}, cyc, ecyc);
    check({nm, " result"}, result, er);
    check({nm, " exc"}, 32'(exc), 32'(ee));
    $display("[TB] %s: result=%h exc=%0d done at cycle %0d", nm, result, exc, cyc);
    repeat (2) @(negedge clk);
    check({nm, " result held"}, result, er);
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1'b1; start = 1'b0; word_op = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
`ifdef DIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset exc", 32'(exc), 32'd0);
    check("reset result", result, 32'h0);
    rst = 1'b0;

    run_op("udiv word 100/7",  1, 0, 32'h0000_0064, 16'h0007, 32'h0002_000E, 0, 19, 0);
    run_op("idiv byte -7/2",   0, 1, 32'hABCD_FFF9, 16'h5502, 32'h0000_FFFD, 0, 11, 0);
    run_op("div by zero",      1, 0, 32'h1234_5678, 16'h0000, 32'h0000_0000, 1, 2, 0);
    run_op("udiv word ovf",    1, 0, 32'h0002_0000, 16'h0001, 32'h0000_0000, 1, 2, 0);
    run_op("idiv word ovf",    1, 1, 32'h0000_8000, 16'h0001, 32'h0000_0000, 1, 19, 0);
    run_op("idiv word min",    1, 1, 32'hFFFF_8000, 16'h0001, 32'h0000_8000, 0, 19, 0);
    run_op("start while busy", 1, 0, 32'h0000_0064, 16'h0007, 32'h0002_000E, 0, 19, 5);
    run_op("udiv word max",    1, 0, 32'hFFFE_FFFF, 16'hFFFF, 32'hFFFE_FFFF, 0, 19, 0);
    run_op("idiv -100/7",      1, 1, 32'hFFFF_FF9C, 16'h0007, 32'hFFFE_FFF2, 0, 19, 0);
    run_op("idiv 100/-7",      1, 1, 32'h0000_0064, 16'hFFF9, 32'h0002_FFF2, 0, 19, 0);
    run_op("udiv byte 100/7",  0, 0, 32'h0000_0064, 16'h0007, 32'h0000_020E, 0, 11, 0);
    run_op("idiv byte -128/-1",0, 1, 32'h0000_FF80, 16'h00FF, 32'h0000_0000, 1, 11, 0);
    run_op("byte zero div",    0, 0, 32'h0000_0064, 16'h0100, 32'h0000_0000, 1, 2, 0);
    run_op("udiv byte ovf",    0, 0, 32'h0000_0700, 16'h0007, 32'h0000_0000, 1, 2, 0);

    // Synchronous reset in the middle of an iteration.
    @(negedge clk);
    word_op = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst result", result, 32'h0);
    check("rst exc", 32'(exc), 32'd0);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (done) seen = 1'b1; end
    check("rst no done", 32'(seen), 32'd0);
    $display("[TB] reset at cycle 8: busy=%0d result=%h", busy, result);
    run_op("after rst 1000/3", 1, 0, 32'd1000, 16'd3, 32'h0001_014D, 0, 19, 0);

`ifdef DIV_ABORT_EN
    // Abort raised together with start is ignored; abort at cycle 8 cancels.
    @(negedge clk);
    word_op = 1'b1; signed_op = 1'b0; dividend = 32'd500; divisor = 16'd9;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cyc = 1;
    while (cyc < 8) begin @(negedge clk); cyc++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result kept", result, 32'h0001_014D);
    check("abort exc kept", 32'(exc), 32'd0);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (done) seen = 1'b1; end
    check("abort no done", 32'(seen), 32'd0);
    $display("[TB] abort at cycle 8: busy=%0d result=%h", busy, result);
    run_op("after abort 500/9", 1, 0, 32'd500, 16'd9, 32'h0005_0037, 0, 19, 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
